// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC generation, 1-cycle synchronous imem fetch, 2-entry output queue with flushing redirect.
module if_fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next_state;
  logic [ADDR_W-1:0] r_fetch_pc, r_req_pc;
  logic [1:0] r_count;
  logic r_inflight, r_kill;
  logic [DATA_W-1:0] r_q_inst [2];
  logic [ADDR_W-1:0] r_q_pc [2];
  logic w_pop, w_push, w_room, w_wr_idx;
  logic [2:0] w_occ;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next_state;
  always_comb w_next_state = RUN;
  assign out_valid = r_count != 2'd0;
  assign out_inst  = r_q_inst[0];
  assign out_pc    = r_q_pc[0];
  assign w_pop     = out_valid & out_ready;
  // credit check: queued + in-flight after this cycle's pop must leave room for one more
  assign w_occ     = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_room    = w_occ < 3'd2;
  assign w_push    = r_inflight & !r_kill;
  assign w_wr_idx  = r_count[0] ^ w_pop;
  always_comb begin
    imem_req  = (r_state == RUN) & !redirect_valid & w_room;
    imem_addr = r_fetch_pc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_q_inst   <= '{default: '0};
      r_q_pc     <= '{default: '0};
    end else begin
      r_inflight <= imem_req;
      r_kill     <= redirect_valid & r_inflight;
      if (imem_req) r_req_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_count    <= 2'd0;
        r_fetch_pc <= redirect_pc & ~ADDR_W'(3);
      end else begin
        if (imem_req) r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
        r_count <= r_count - {1'b0, w_pop} + {1'b0, w_push};
        if (w_pop) begin
          r_q_inst[0] <= r_q_inst[1];
          r_q_pc[0]   <= r_q_pc[1];
        end
        // later write wins over the shift when push lands on the head slot
        if (w_push) begin
          r_q_inst[w_wr_idx] <= imem_rdata;
          r_q_pc[w_wr_idx]   <= r_req_pc;
        end
      end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: table-driven cycle checks of fetch, backpressure, redirect, PC wrap and async reset.
module tb_if_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, out_valid, out_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_inst, out_pc;
  logic w2_req, w2_valid;
  logic [31:0] w2_addr, w2_rdata, w2_inst, w2_pc;
  int errors = 0, checks = 0;

  typedef struct {
    logic rdy; logic rv; logic [31:0] rpc;
    logic v; logic [31:0] pc; logic req; logic [31:0] addr;
    logic wchk; logic [31:0] wpc;
  } vec_t;
  vec_t tv [25];

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_addr ^ K;
  always @(posedge clk) w2_rdata <= w2_addr ^ K;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w2_req), .imem_addr(w2_addr), .imem_rdata(w2_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(w2_valid),
    .out_ready(1'b1), .out_inst(w2_inst), .out_pc(w2_pc));

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      out_ready = tv[i].rdy;
      redirect_valid = tv[i].rv;
      redirect_pc = tv[i].rpc;
      #1;
      chk("out_valid", i, {31'b0, out_valid}, {31'b0, tv[i].v});
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, tv[i].req});
      if (tv[i].v) begin
        chk("out_pc", i, out_pc, tv[i].pc);
        chk("out_inst", i, out_inst, tv[i].pc ^ K);
      end
      if (tv[i].req) chk("imem_addr", i, imem_addr, tv[i].addr);
      if (tv[i].wchk) begin
        chk("wrap_valid", i, {31'b0, w2_valid}, 32'd1);
        chk("wrap_pc", i, w2_pc, tv[i].wpc);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tv[0]  = '{1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0};
    tv[1]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h0,   0, 32'h0};
    tv[2]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h4,   0, 32'h0};
    tv[3]  = '{1, 0, 32'h0,   1, 32'h0,   1, 32'h8,   1, 32'hFFFF_FFF8};
    tv[4]  = '{1, 0, 32'h0,   1, 32'h4,   1, 32'hC,   1, 32'hFFFF_FFFC};
    tv[5]  = '{1, 0, 32'h0,   1, 32'h8,   1, 32'h10,  1, 32'h0};
    tv[6]  = '{1, 1, 32'h103, 1, 32'hC,   0, 32'h0,   0, 32'h0};
    tv[7]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0};
    tv[8]  = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h104, 0, 32'h0};
    tv[9]  = '{1, 0, 32'h0,   1, 32'h100, 1, 32'h108, 0, 32'h0};
    tv[10] = '{0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   0, 32'h0};
    tv[11] = '{0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   0, 32'h0};
    tv[12] = '{0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   0, 32'h0};
    tv[13] = '{1, 0, 32'h0,   1, 32'h104, 1, 32'h10C, 0, 32'h0};
    tv[14] = '{0, 0, 32'h0,   1, 32'h108, 0, 32'h0,   0, 32'h0};
    tv[15] = '{0, 1, 32'h2FF, 1, 32'h108, 0, 32'h0,   0, 32'h0};
    tv[16] = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h2FC, 0, 32'h0};
    tv[17] = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0};
    tv[18] = '{1, 0, 32'h0,   1, 32'h2FC, 1, 32'h304, 0, 32'h0};
    tv[19] = '{1, 0, 32'h0,   1, 32'h300, 1, 32'h308, 0, 32'h0};
    tv[20] = '{1, 1, 32'h400, 1, 32'h304, 0, 32'h0,   0, 32'h0};
    tv[21] = '{1, 1, 32'h500, 0, 32'h0,   0, 32'h0,   0, 32'h0};
    tv[22] = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h0};
    tv[23] = '{1, 0, 32'h0,   0, 32'h0,   1, 32'h504, 0, 32'h0};
    tv[24] = '{1, 0, 32'h0,   1, 32'h500, 1, 32'h508, 0, 32'h0};
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", -1, {31'b0, out_valid}, 32'd0);
    chk("rst_req", -1, {31'b0, imem_req}, 32'd0);
    chk("rst_inst", -1, out_inst, 32'h0);
    chk("rst_pc", -1, out_pc, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run_rows(0, 24);
    // fill the queue under backpressure, then drop reset asynchronously mid-cycle
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("full_valid", 26, {31'b0, out_valid}, 32'd1);
    chk("full_pc", 26, out_pc, 32'h504);
    chk("full_req", 26, {31'b0, imem_req}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 27, {31'b0, out_valid}, 32'd0);
    chk("async_req", 27, {31'b0, imem_req}, 32'd0);
    chk("async_pc", 27, out_pc, 32'h0);
    chk("async_inst", 27, out_inst, 32'h0);
    chk("async_wrap_valid", 27, {31'b0, w2_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_rows(0, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
